seg7_monitor: RTL and testbench
===============================

SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples of seg_in required before a pattern is accepted; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 seg_in  input  7  active-low segment bus, bit0=a .. bit6=g, driven by the 7-segment hex counter output.
REQ-005 digit  output  4  last accepted decoded hex value.
REQ-006 digit_valid  output  1  one-cycle strobe: digit updated this cycle.
REQ-007 bad_pattern  output  1  one-cycle strobe: accepted pattern is not one of the 16 legal codes.
REQ-008 seq_err  output  1  one-cycle strobe: legal digit out of counting sequence.
REQ-009 locked  output  1  high while the sequence tracker is in TRACK.
REQ-010 err_count  output  8  saturating count of bad_pattern plus seq_err events.

Function
REQ-011 Legal codes, hex value:pattern (7-bit hex) SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E; any other pattern is illegal.
REQ-012 seg_in SHALL be registered once; the stability counter increments while registered sample equals previous sample, and reloads to 1 on any change.
REQ-013 A pattern SHALL be accepted in the cycle its stability count reaches STABLE_CYCLES, and only if it differs from the last accepted pattern; a held pattern is accepted once.
REQ-014 Latency: seg_in change to digit_valid/bad_pattern SHALL be STABLE_CYCLES+1 cycles.
REQ-015 Accepted legal pattern: digit loads decoded value, digit_valid pulses; accepted illegal pattern: digit holds, bad_pattern pulses, digit_valid stays low.
REQ-016 Tracker FSM states HUNT and TRACK; expected register 4 bits.
REQ-017 HUNT: accepted legal digit d -> TRACK, expected = d+1 mod 16, no seq_err.
REQ-018 TRACK: d == expected -> stay, expected = d+1 mod 16 (F wraps to 0 without error).
REQ-019 TRACK: d == 0 and expected != 0 -> counter restart; stay TRACK, expected = 1, no seq_err.
REQ-020 TRACK: any other legal d -> seq_err pulse, go HUNT.
REQ-021 Any illegal accepted pattern -> HUNT from either state.
REQ-022 err_count SHALL increment by 1 per bad_pattern or seq_err pulse (never both in one cycle), saturating at 255.
REQ-023 locked SHALL equal (state == TRACK), registered.

Reset
REQ-024 rst high at a rising edge SHALL clear: digit=0, strobes=0, locked=0, err_count=0, state=HUNT, expected=0, stability count=0, last accepted pattern=7F (blank), sample registers=7F.
REQ-025 rst mid-filter or mid-sequence SHALL discard partial stability count; first acceptance after reset needs full STABLE_CYCLES.

Configuration
REQ-026 Macro SEG7_MONITOR_SEQ_CHECK_EN defined: tracker FSM, seq_err, locked and seq_err contribution to err_count present per REQ-016..023.
REQ-027 Macro undefined: no FSM or expected register; seq_err and locked tied 0; err_count counts bad_pattern only; decode/filter unchanged.

Structure
REQ-028 Package seg7_pkg SHALL hold the 16 segment-pattern constants, blank pattern 7F, and the tracker state enumeration.
REQ-029 Combinational pattern-to-value lookup with legal flag SHALL be sub-module seg7_decode; filter, FSM and counters stay in seg7_monitor.

Verification
REQ-030 Drive 40,79,24 each held 6 cycles, STABLE_CYCLES=4 -> digit_valid with 0,1,2; locked high after first; seq_err never.
REQ-031 Full 0..F then 0 sequence -> 17 digit_valid, F->0 wrap no seq_err, err_count=0.
REQ-032 Glitch: 12 for 3 cycles between stable 19 and 02 -> no acceptance of 12, digits 4 then 6 but 6 flags seq_err, err_count=1, locked low.
REQ-033 Illegal 7F held 8 cycles while locked -> one bad_pattern pulse, locked low, digit unchanged.
REQ-034 300 alternating 00/7F events -> err_count saturates at 255; rst mid-hold -> all outputs zero next cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment monitor: legal active-low segment codes,
// the blank pattern and the sequence-tracker state encodings.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Index is the hex value shown by the pattern
   localparam logic [6:0] SEG_CODE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   localparam logic [0:0] ST_HUNT  = 1'b0;
   localparam logic [0:0] ST_TRACK = 1'b1;

endpackage

// File: rtl/seg7_monitor_if.sv
// Segment bus plus monitor result signals; master drives the segment bus,
// slave is the monitor that reports decoded digits and error strobes.
interface seg7_monitor_if;

   logic [6:0] seg_in;
   logic [3:0] digit;
   logic       digit_valid;
   logic       bad_pattern;
   logic       seq_err;
   logic       locked;
   logic [7:0] err_count;

   modport master (
      output seg_in,
      input  digit, digit_valid, bad_pattern, seq_err, locked, err_count
   );

   modport slave (
      input  seg_in,
      output digit, digit_valid, bad_pattern, seq_err, locked, err_count
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to hex-value lookup with a legal-code flag.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] value,
   output logic       legal
);

   always_comb begin
      value = '0;
      legal = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (pattern == SEG_CODE[i]) begin
            value = 4'(i);
            legal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_monitor.sv
// Filters and decodes a 7-segment hex counter bus and flags illegal or
// out-of-sequence digits. Define SEG7_MONITOR_SEQ_CHECK_EN to add the tracker.
module seg7_monitor
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic           clk,
   input logic           rst,
   seg7_monitor_if.slave mon
);

   localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

   logic [6:0] sample;
   logic [6:0] prev;
   logic [6:0] last_acc;
   logic [3:0] stab_cnt;
   logic [3:0] dec_value;
   logic       dec_legal;
   logic       accept;
   logic       valid_next;
   logic       bad_next;
   logic       seq_next;

   logic [3:0] digit;
   logic       digit_valid;
   logic       bad_pattern;
   logic       seq_err;
   logic [7:0] err_count;

   seg7_decode u_decode (
      .pattern (prev),
      .value   (dec_value),
      .legal   (dec_legal)
   );

   // The count saturates at STAB, so last_acc is what keeps a held pattern
   // from being accepted more than once.
   assign accept     = (stab_cnt == STAB) && (prev != last_acc);
   assign valid_next = accept && dec_legal;
   assign bad_next   = accept && !dec_legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         sample      <= SEG_BLANK;
         prev        <= SEG_BLANK;
         last_acc    <= SEG_BLANK;
         stab_cnt    <= '0;
         digit       <= '0;
         digit_valid <= 1'b0;
         bad_pattern <= 1'b0;
         seq_err     <= 1'b0;
         err_count   <= '0;
      end else begin
         sample <= mon.seg_in;
         prev   <= sample;
         if (sample != prev)
            stab_cnt <= 4'd1;
         else if (stab_cnt != STAB)
            stab_cnt <= stab_cnt + 4'd1;
         if (accept)
            last_acc <= prev;
         if (valid_next)
            digit <= dec_value;
         digit_valid <= valid_next;
         bad_pattern <= bad_next;
         seq_err     <= seq_next;
         if ((bad_next || seq_next) && (err_count != '1))
            err_count <= err_count + 8'd1;
      end
   end

`ifdef SEG7_MONITOR_SEQ_CHECK_EN
   logic [0:0] state;
   logic [0:0] state_next;
   logic [3:0] expected;
   logic [3:0] expected_next;
   logic       locked;

   always_comb begin
      state_next    = state;
      expected_next = expected;
      seq_next      = 1'b0;
      if (bad_next) begin
         state_next = ST_HUNT;
      end else if (valid_next) begin
         if (state == ST_HUNT) begin
            state_next    = ST_TRACK;
            expected_next = dec_value + 4'd1;
         end else if (dec_value == expected) begin
            expected_next = dec_value + 4'd1;
         end else if (dec_value == 4'd0) begin
            expected_next = 4'd1;
         end else begin
            seq_next   = 1'b1;
            state_next = ST_HUNT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_HUNT;
         expected <= '0;
         locked   <= 1'b0;
      end else begin
         state    <= state_next;
         expected <= expected_next;
         locked   <= (state_next == ST_TRACK);
      end
   end

   assign mon.locked = locked;
`else
   assign seq_next   = 1'b0;
   assign mon.locked = 1'b0;
`endif

   assign mon.digit       = digit;
   assign mon.digit_valid = digit_valid;
   assign mon.bad_pattern = bad_pattern;
   assign mon.seq_err     = seq_err;
   assign mon.err_count   = err_count;

endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: directed and random segment-bus runs checked every
// cycle against a run-length reference model of the acceptance rules.
module tb_seg7_monitor;

   localparam int unsigned S = 4;
   localparam logic [6:0] CODE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
`ifdef SEG7_MONITOR_SEQ_CHECK_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   seg7_monitor_if bus ();

   seg7_monitor #(.STABLE_CYCLES(S)) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  digit;
      logic        valid;
      logic        bad;
      logic        seq;
      logic        locked;
      logic [7:0]  errs;
   } ev_t;

   ev_t evq[$];

   int unsigned cyc = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned n_valid = 0;
   int unsigned n_bad = 0;

   // Model state as of the most recently scheduled acceptance
   logic [6:0]  m_last;
   bit          m_track;
   logic [3:0]  m_exp;
   logic [3:0]  m_digit;
   int unsigned m_errs;

   logic [6:0]  run_pat;
   int unsigned run_start;
   int unsigned run_len;
   bit          run_valid;

   // Output values the DUT should present in the current cycle
   logic [3:0]  e_digit;
   logic        e_valid, e_bad, e_seq, e_locked;
   logic [7:0]  e_errs;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_last = 7'h7F; m_track = 1'b0; m_exp = '0; m_digit = '0; m_errs = 0;
      e_digit = '0; e_valid = 1'b0; e_bad = 1'b0; e_seq = 1'b0;
      e_locked = 1'b0; e_errs = '0;
      run_valid = 1'b0;
      evq.delete();
   endtask

   task automatic schedule(input logic [6:0] pat);
      ev_t ev;
      bit  legal = 1'b0;
      int  val = 0;
      for (int i = 0; i < 16; i++)
         if (CODE[i] == pat) begin legal = 1'b1; val = i; end
      ev.valid = 1'b0; ev.bad = 1'b0; ev.seq = 1'b0;
      if (legal) begin
         ev.valid = 1'b1;
         m_digit  = 4'(val);
         if (SEQ_EN) begin
            if (!m_track) begin
               m_track = 1'b1;
               m_exp   = 4'((val + 1) % 16);
            end else if (val == int'(m_exp)) begin
               m_exp = 4'((val + 1) % 16);
            end else if (val == 0) begin
               m_exp = 4'd1;
            end else begin
               ev.seq  = 1'b1;
               m_track = 1'b0;
            end
         end
      end else begin
         ev.bad  = 1'b1;
         m_track = 1'b0;
      end
      if ((ev.bad || ev.seq) && m_errs < 255) m_errs++;
      m_last    = pat;
      ev.cyc    = run_start + S + 1;
      ev.digit  = m_digit;
      ev.locked = m_track;
      ev.errs   = 8'(m_errs);
      evq.push_back(ev);
   endtask

   task automatic step(input logic [6:0] pat, input logic r);
      bus.seg_in = pat;
      rst = r;
      @(posedge clk);
      cyc++;
      if (r) begin
         model_reset();
      end else begin
         if (run_valid && pat == run_pat) begin
            run_len++;
         end else begin
            run_pat = pat; run_start = cyc; run_len = 1; run_valid = 1'b1;
         end
         if (run_len == S && pat != m_last) schedule(pat);
      end
      #1;
      e_valid = 1'b0; e_bad = 1'b0; e_seq = 1'b0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
         e_digit  = evq[0].digit;
         e_valid  = evq[0].valid;
         e_bad    = evq[0].bad;
         e_seq    = evq[0].seq;
         e_locked = evq[0].locked;
         e_errs   = evq[0].errs;
         void'(evq.pop_front());
      end
      vectors++;
      chk("digit",       {4'h0, bus.digit},   {4'h0, e_digit});
      chk("digit_valid", {7'h0, bus.digit_valid}, {7'h0, e_valid});
      chk("bad_pattern", {7'h0, bus.bad_pattern}, {7'h0, e_bad});
      chk("seq_err",     {7'h0, bus.seq_err}, {7'h0, e_seq});
      chk("locked",      {7'h0, bus.locked},  {7'h0, e_locked});
      chk("err_count",   bus.err_count,       e_errs);
      if (bus.digit_valid === 1'b1) n_valid++;
      if (bus.bad_pattern === 1'b1) n_bad++;
   endtask

   task automatic hold(input logic [6:0] pat, input int unsigned n);
      repeat (n) step(pat, 1'b0);
   endtask

   task automatic do_reset(input logic [6:0] pat, input int unsigned n);
      repeat (n) step(pat, 1'b1);
   endtask

   initial begin
      logic [6:0]  rpat;
      int unsigned rval;
      int unsigned pick;

      model_reset();
      do_reset(7'h7F, 3);
      hold(7'h7F, 2);

      // Three digits in counting order
      n_valid = 0;
      hold(7'h40, 6); hold(7'h79, 6); hold(7'h24, 6); hold(7'h24, 2);
      chk("first3_valid_cnt", 8'(n_valid), 8'd3);

      // Full count 0..F with wrap back to 0
      n_valid = 0;
      for (int i = 0; i < 16; i++) hold(CODE[i], 6);
      hold(CODE[0], 8);
      chk("seq17_valid_cnt", 8'(n_valid), 8'd17);
      chk("seq17_err_count", bus.err_count, 8'd0);

      // Short glitch between two stable legal digits
      do_reset(7'h7F, 1);
      n_valid = 0;
      hold(7'h19, 8); hold(7'h12, 3); hold(7'h02, 8);
      chk("glitch_valid_cnt", 8'(n_valid), 8'd2);
      chk("glitch_digit", {4'h0, bus.digit}, 8'h06);
      chk("glitch_errs", bus.err_count, SEQ_EN ? 8'd1 : 8'd0);

      // Blank held while locked
      hold(7'h40, 6); hold(7'h79, 6);
      n_bad = 0;
      hold(7'h7F, 8); hold(7'h7F, 2);
      chk("blank_bad_cnt", 8'(n_bad), 8'd1);
      chk("blank_digit", {4'h0, bus.digit}, 8'h01);

      // Random runs: mostly next-in-sequence, some random legal, some raw bits
      rval = 0;
      for (int k = 0; k < 160; k++) begin
         pick = $urandom_range(0, 9);
         if (pick < 5) begin
            rval = (rval + 1) % 16;
            rpat = CODE[rval];
         end else if (pick < 8) begin
            rval = $urandom_range(0, 15);
            rpat = CODE[rval];
         end else begin
            rpat = 7'($urandom);
         end
         if ($urandom_range(0, 39) == 0) do_reset(rpat, 1);
         hold(rpat, $urandom_range(1, 7));
      end

      // Saturation of the error counter
      do_reset(7'h7F, 1);
      for (int k = 0; k < 300; k++) begin
         hold(7'h00, S); hold(7'h7F, S);
      end
      hold(7'h7F, S + 2);
      chk("err_saturated", bus.err_count, 8'd255);

      // Reset in the middle of a hold, then a full-length first acceptance
      hold(7'h00, 2);
      step(7'h00, 1'b1);
      chk("rst_digit", {4'h0, bus.digit}, 8'h00);
      chk("rst_errs", bus.err_count, 8'd0);
      n_valid = 0;
      hold(7'h00, S + 1);
      chk("rst_no_early_accept", 8'(n_valid), 8'd0);
      hold(7'h00, 3);
      chk("rst_then_accept", 8'(n_valid), 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
